mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
Multi-cycle radix-2 shift-add multiply sequencer. It replaces the single-cycle 16x16 combinational multiplier in the MiniAlu datapath for MULU/MULS.
It accepts two operands plus a destination address on a start pulse, iterates one bit per cycle, and returns a 32-bit product as low/high halves. It drives the write-back strobes the dual-read-port RAM needs: low half to the destination register, high half through the high-part port. The decode stage stalls the IP while oBusy is high.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH.
ADDR_W, 8, destination address width.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
iStart  in  1  request; sampled only when the block is accepting (see Behaviour).
iSigned  in  1  1 = two's-complement multiply (MULS), 0 = unsigned (MULU); latched with iStart.
iOperandA  in  WIDTH  multiplicand; latched with iStart.
iOperandB  in  WIDTH  multiplier; latched with iStart.
iDestination  in  ADDR_W  write-back register address; latched with iStart.
oBusy  out  1  high while the operation is in progress (RUN, SIGN).
oDone  out  1  one-cycle pulse; results valid.
oResultLow  out  WIDTH  product[WIDTH-1:0].
oResultHigh  out  WIDTH  product[2*WIDTH-1:WIDTH].
oDestination  out  ADDR_W  latched destination address.
oWriteEnable  out  1  equals oDone; RAM write strobe for the low half.
oMulEnable  out  1  equals oDone; RAM high-part write strobe.

Behaviour:
- Reset state: state IDLE; counter 0; all outputs 0.
- Reset in any state, including mid-RUN, takes priority over everything:
  - next state IDLE, accumulator cleared;
  - no oDone is issued for the aborted operation.
- States: IDLE, RUN, SIGN, DONE.
- Accepting states are IDLE and DONE. Back-to-back starts are legal; iStart in RUN or SIGN is ignored and is not queued.
- Accept, at edge E (iStart=1 in an accepting state):
  - latch iSigned and iDestination;
  - latch magnitudes |A| and |B|: two's-complement absolute value when iSigned, raw value otherwise;
  - latch negate flag = iSigned & (A[MSB] ^ B[MSB]);
  - clear the 2*WIDTH accumulator; counter = WIDTH-1; next state RUN.
- RUN, one multiplier bit per cycle, LSB first:
  - if the current multiplier bit is 1, add the shifted multiplicand into the accumulator;
  - the adder is WIDTH+1 bits wide so the carry is kept;
  - at counter 0, go to SIGN; otherwise decrement the counter.
  - RUN lasts exactly WIDTH cycles.
- SIGN, one cycle: if the negate flag is set, two's-complement the full 2*WIDTH accumulator. Next state DONE.
- DONE, one cycle:
  - oDone = oWriteEnable = oMulEnable = 1;
  - next state is IDLE, or RUN if iStart=1.
- Latency: accept at edge E puts oBusy high for cycles E+1 .. E+WIDTH+1 and pulses oDone in cycle E+WIDTH+2 (cycle 18 for WIDTH=16).
- Result outputs and oDestination hold their last value until the next DONE; they change only on the DONE-entry edge.
- Magnitude of the most-negative value is 2^(WIDTH-1). It must be handled as unsigned WIDTH bits, not overflow. Example: -32768 * -32768 = 0x4000_0000.
- Unsigned results never need the SIGN correction, but still pass through SIGN so latency is fixed regardless of mode.
- Zero operands take full latency; there is no early termination.

Decomposition:
- Shared definitions include (alongside the opcode defines): state encodings MS_IDLE=2'd0, MS_RUN=2'd1, MS_SIGN=2'd2, MS_DONE=2'd3, and the default MUL_WIDTH=16.
- One sub-module, mul_shift_add_core. It holds the accumulator/multiplicand/multiplier registers, the (WIDTH+1)-bit adder and the final negation, and takes load/step/negate controls.
- The FSM, counter and handshake stay in mul_sequencer.

Test Plan:
- Unsigned: start with A=0xFFFF, B=0xFFFF, iSigned=0, iDestination=0x05 at edge 0 → oBusy high cycles 1-17; oDone in cycle 18 with Low=0x0001, High=0xFFFE, oDestination=0x05; oWriteEnable = oMulEnable = 1 for that cycle only.
- Signed mixed sign: A=0xFFFD (-3), B=0x0005, iSigned=1 → High=0xFFFF, Low=0xFFF1. Repeat with iSigned=0 → High=0x0004, Low=0xFFF1.
- Signed boundary, each checked at cycle 18:
  - A=B=0x8000, iSigned=1 → 0x4000_0000.
  - A=0x8000, B=0x0001 → 0xFFFF_8000.
  - A=0x0000, B=0x8000 → 0x0000_0000.
- Handshake: iStart re-asserted with different operands in cycles 5 and 17 → ignored; a single oDone carries the first result. Then iStart in the DONE cycle with A=2, B=3 → accepted, next oDone 18 cycles later with product 6.
- Reset mid-operation: Reset=1 in cycle 9 of a 7*9 multiply → next cycle IDLE, oBusy=0, outputs 0, no oDone. A subsequent 7*9 returns 0x003F at normal latency.
- Reset held with iStart=1 → stays IDLE and nothing is accepted. After release, the first iStart is accepted on that edge.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier:
// sequencer state encodings and the default operand width.
package mul_sequencer_pkg;

    localparam int MUL_WIDTH = 16;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_RUN  = 2'd1;
    localparam logic [1:0] MS_SIGN = 2'd2;
    localparam logic [1:0] MS_DONE = 2'd3;

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath: operates on operand magnitudes and applies
// the sign as a final two's-complement step.
module mul_shift_add_core
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               negate_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] final_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   mag_a, mag_b, addend;
    logic [WIDTH:0]     sum;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
    assign mag_a  = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b  = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
    assign addend = mplier_q[0] ? mcand_q : '0;
    assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign final_o = neg_q ? -acc_q : acc_q;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mag_a;
            mplier_d = mag_b;
            neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (step_i) begin
            // Add into the high half, then shift the whole accumulator right.
            acc_d    = {sum, acc_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
        end else if (negate_i) begin
            acc_d = final_o;
            neg_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MULU/MULS sequencer: FSM, bit counter and RAM write-back
// handshake around the shift-add core.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH  = MUL_WIDTH,
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic              iSigned,
    input  logic [WIDTH-1:0]  iOperandA,
    input  logic [WIDTH-1:0]  iOperandB,
    input  logic [ADDR_W-1:0] iDestination,
    output logic              oBusy,
    output logic              oDone,
    output logic [WIDTH-1:0]  oResultLow,
    output logic [WIDTH-1:0]  oResultHigh,
    output logic [ADDR_W-1:0] oDestination,
    output logic              oWriteEnable,
    output logic              oMulEnable
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  dest_lat_q, dest_lat_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [2*WIDTH-1:0] product;
    logic               accept;

    assign accept = iStart & ((state_q == MS_IDLE) | (state_q == MS_DONE));

    mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .load_i   (accept),
        .step_i   (state_q == MS_RUN),
        .negate_i (state_q == MS_SIGN),
        .signed_i (iSigned),
        .a_i      (iOperandA),
        .b_i      (iOperandB),
        .final_o  (product)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dest_lat_d = dest_lat_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        dst_d      = dst_q;
        case (state_q)
            MS_IDLE, MS_DONE: begin
                state_d = MS_IDLE;
                if (accept) begin
                    state_d    = MS_RUN;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    dest_lat_d = iDestination;
                end
            end
            MS_RUN: begin
                if (cnt_q == '0) state_d = MS_SIGN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            MS_SIGN: begin
                // Results are published only on the edge that enters DONE.
                state_d      = MS_DONE;
                {hi_d, lo_d} = product;
                dst_d        = dest_lat_q;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= MS_IDLE;
            cnt_q      <= '0;
            dest_lat_q <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dest_lat_q <= dest_lat_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            dst_q      <= dst_d;
        end
    end

    assign oBusy        = (state_q == MS_RUN) | (state_q == MS_SIGN);
    assign oDone        = (state_q == MS_DONE);
    assign oWriteEnable = oDone;
    assign oMulEnable   = oDone;
    assign oResultLow   = lo_q;
    assign oResultHigh  = hi_q;
    assign oDestination = dst_q;

endmodule
